// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared CPU constants and fetch-buffer entry type
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int          INSTR_W    = 16;
  localparam int          PC_W       = 16;
  localparam logic [15:0] PC_STEP    = 16'd2;
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned; the low address bit is ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_fifo : prefetch buffer of {pc, instr} entries with flush
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // When full, a simultaneous push reuses the slot being popped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : in-order instruction prefetcher with redirect and halt
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            running;
  logic            inflight;
  logic            halt_seen;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            push;
  logic            halt_resp;
  logic            issue;
  fetch_entry_t    resp;
  fetch_entry_t    head;

  assign pop       = instr_valid && instr_ready;
  assign push      = inflight && !redirect;
  assign halt_resp = inflight && (imem_rdata == HALT_INSTR);

  // Occupancy once this cycle's response lands and this cycle's pop leaves.
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = running && !redirect && !halt_seen && !halt_resp
                     && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = pc;
  assign resp      = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halt_seen   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      running <= 1'b1;
      if (redirect) begin
        pc        <= align_pc(redirect_pc);
        inflight  <= 1'b0;
        halt_seen <= 1'b0;
        halted    <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc          <= pc + PC_STEP;
          inflight_pc <= pc;
        end
        if (halt_resp) halt_seen <= 1'b1;
        if (pop && instr == HALT_INSTR) halted <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (push),
    .push_data  (resp),
    .pop        (pop),
    .head       (head),
    .head_valid (instr_valid),
    .count      (count)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed scoreboard bench for fetch_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        imem_en, instr_valid, instr_ready, redirect, halted;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;

  logic        imem_en_w, instr_valid_w, ready_w, redirect_w, halted_w;
  logic [15:0] imem_addr_w, imem_rdata_w, instr_w, instr_pc_w, redirect_pc_w;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'hFFFC)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .instr(instr_w), .instr_pc(instr_pc_w),
    .instr_valid(instr_valid_w), .instr_ready(ready_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .halted(halted_w)
  );

  // Program image: halt at byte address 18, zeros elsewhere.
  function automatic logic [15:0] img(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h710F;
      16'h0002: return 16'h6B07;
      16'h0004: return 16'h1234;
      16'h0006: return 16'h2345;
      16'h0008: return 16'h3456;
      16'h000A: return 16'h4567;
      16'h000C: return 16'h5678;
      16'h000E: return 16'h6789;
      16'h0010: return 16'h789A;
      16'h0012: return 16'hFFFF;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (imem_en)   imem_rdata   <= img(imem_addr);
    if (imem_en_w) imem_rdata_w <= imem_addr_w ^ 16'h5A5A;
  end

  typedef struct { logic [15:0] pc; logic [15:0] ins; } exp_t;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a += 2) sb_q.push_back('{pc: 16'(a), ins: img(16'(a))});
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      next_cycle();
      @(negedge clock);
      n++;
    end
    check(name, 32'(halted), 32'd1);
    check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every accepted transfer is compared against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual pc %0h instr %0h, required no transfer",
                 instr_pc, instr);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(e.pc));
        check("sb_instr", 32'(instr), 32'(e.ins));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    ready_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_imem_en", 32'(imem_en), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr", 32'({instr, instr_pc}), 32'd0);
    check("rst_wrap_en", 32'(imem_en_w), 32'd0);

    // Straight-line run to halt, plus the wrapping instance.
    next_cycle();
    reset_n = 1'b1; instr_ready = 1'b1; ready_w = 1'b1;
    push_range(0, 18);
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      @(negedge clock);
      if (c == 0) check("issue_pc0", 32'({imem_en, imem_addr}), 32'h1_0000);
      if (c == 1) check("no_valid_c1", 32'(instr_valid), 32'd0);
      if (c >= 2 && c <= 11)
        check("stream_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, 16'(2*(c-2))}));
      if (c == 9) check("issue_pc18", 32'({imem_en, imem_addr}), 32'h1_0012);
      if (c >= 10) check("no_fetch_after_halt", 32'(imem_en), 32'd0);
      if (c == 11) check("halted_not_yet", 32'(halted), 32'd0);
      if (c >= 12) check("halted", 32'(halted), 32'd1);
      if (c == 2) check("wrap_addr", 32'({imem_en_w, imem_addr_w}), 32'h1_0000);
      if (c >= 2 && c <= 5) begin
        check("wrap_pc", 32'({instr_valid_w, instr_pc_w}),
              32'({1'b1, 16'(32'hFFFC + 2*(c-2))}));
        check("wrap_instr", 32'(instr_w), 32'(16'(32'hFFFC + 2*(c-2)) ^ 16'h5A5A));
      end
    end
    check("drain_t1", 32'(sb_q.size()), 32'd0);

    // Redirect out of halt to an odd target.
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0003;
    push_range(2, 18);
    @(negedge clock);
    check("redir_blocks_issue", 32'(imem_en), 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clock);
    check("halt_cleared", 32'(halted), 32'd0);
    check("redir_fetch_2", 32'({imem_en, imem_addr}), 32'h1_0002);
    check("redir_flush", 32'(instr_valid), 32'd0);
    wait_halted(20, "halt_t2");

    // Backpressure for five cycles after the first valid.
    next_cycle();
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0000;
    push_range(0, 18);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 0) redirect = 1'b0;
      if (c == 7) instr_ready = 1'b1;
      @(negedge clock);
      if (c == 0) check("bp_issue0", 32'({imem_en, imem_addr}), 32'h1_0000);
      if (c >= 2 && c <= 6) begin
        check("bp_hold", 32'({instr_valid, instr_pc}), 32'h1_0000);
        check("bp_hold_instr", 32'(instr), 32'h710F);
        check("bp_stall", 32'(imem_en), 32'd0);
      end
      if (c == 7) check("bp_resume", 32'({imem_en, imem_addr}), 32'h1_0004);
      if (c >= 7) check("bp_order", 32'({instr_valid, instr_pc}), 32'({1'b1, 16'(2*(c-7))}));
    end
    wait_halted(20, "halt_t3");

    // Redirect while the read of address 6 is outstanding.
    next_cycle();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0000;
    push_range(0, 4);
    push_range(12, 18);
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      if (c == 0) redirect = 1'b0;
      if (c == 4) begin redirect = 1'b1; redirect_pc = 16'h000C; end
      if (c == 5) redirect = 1'b0;
      @(negedge clock);
      if (c == 3) check("pending_addr6", 32'({imem_en, imem_addr}), 32'h1_0006);
      if (c == 4) check("redir_no_issue", 32'(imem_en), 32'd0);
      if (c == 5) begin
        check("redir_gap1", 32'(instr_valid), 32'd0);
        check("redir_fetch_c", 32'({imem_en, imem_addr}), 32'h1_000C);
      end
      if (c == 6) check("redir_gap2", 32'(instr_valid), 32'd0);
      if (c == 7) check("redir_first", 32'({instr_valid, instr_pc}), 32'h1_000C);
    end
    wait_halted(20, "halt_t4");

    // Asynchronous reset while the buffer is full.
    next_cycle();
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0000;
    next_cycle();
    redirect = 1'b0;
    repeat (4) next_cycle();
    @(negedge clock);
    check("full_before_reset", 32'({instr_valid, imem_en}), 32'b10);
    next_cycle();
    #1 reset_n = 1'b0;
    #1;
    check("arst_imem_en", 32'(imem_en), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_instr", 32'({instr, instr_pc}), 32'd0);
    check("arst_pc", 32'({imem_addr, imem_addr_w}), 32'h0000_FFFC);
    sb_q.delete();
    #1 reset_n = 1'b1;
    instr_ready = 1'b1;
    push_range(0, 18);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clock);
      if (c == 0) check("restart_issue", 32'({imem_en, imem_addr}), 32'h1_0000);
      if (c == 1) check("restart_gap", 32'(instr_valid), 32'd0);
      if (c == 2) check("restart_first", 32'({instr_valid, instr_pc}), 32'h1_0000);
    end
    wait_halted(20, "halt_t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
